spi_tx_arbiter: RTL
===================

# spi_tx_arbiter

Round-robin arbiter that shares one 8-bit SPI transmitter among NREQ byte-producing requesters. It accepts a byte from the winning requester, starts the transmitter, tracks the transfer through the transmitter's active-high slave select, and reports completion back to that requester. It sits between the application-side byte sources and the SPI TX block, and is the only driver of the transmitter's start/data inputs.

## Interface
Parameters:
- NREQ, 4: number of requesters; must equal 2**IDW.
- IDW, 2: width of grant_id.
- TIMEOUT, 255: watchdog limit in clk cycles (1..255). Used only when SPI_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held high until the matching ack.
- data  in  8*NREQ  packed bytes; requester i at [8i+7:8i]; stable while req[i] is high.
- ack  out  NREQ  one-cycle pulse: byte of requester i latched.
- done  out  NREQ  one-cycle pulse: transfer for requester i finished or aborted.
- busy  out  1  high in every state except IDLE.
- grant_id  out  IDW  index of current/last granted requester.
- err  out  1  one-cycle pulse with done on watchdog abort; constant 0 without the macro.
- tx_start  out  1  start strobe to the SPI transmitter.
- tx_data  out  8  byte to the SPI transmitter; registered.
- tx_ss  in  1  transmitter slave select; high while a byte is shifting.

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: if req != 0, select the first set bit searching upward from last_grant+1 modulo NREQ. At that edge: tx_data <= data of winner, grant_id <= winner, ack[winner] <= 1, go to START. If req == 0, stay.
- START: tx_start = 1. When tx_ss == 1 is sampled, go to WAIT_DONE (tx_start low from the next cycle).
- WAIT_DONE: when tx_ss == 0 is sampled, done[grant_id] <= 1, last_grant <= grant_id, go to GAP.
- GAP: one cycle, covers the transmitter's post-transfer clear cycle; go to IDLE.
- All outputs are registered or decoded from state only; no combinational path from req/tx_ss to outputs.
- Data is captured at the arbitration edge; req dropping after ack has no effect on the transfer. req still high after ack is treated as a new request.
- Requester rotation: the winner becomes lowest priority for the next arbitration, so persistent requesters are served in strict rotation.
- Reset (any time, including mid-transfer): state IDLE, ack/done/err/tx_start/busy 0, tx_data 0, grant_id 0, last_grant NREQ-1 (requester 0 has top priority first).

## Timing
- req[i] sampled high in IDLE at edge n: ack[i], tx_start and busy are high in cycle n+1; tx_data is valid in cycle n+1.
- tx_start stays high until the edge at which tx_ss = 1 is sampled.
- tx_ss sampled low in WAIT_DONE at edge m: done[i] is high in cycle m+1 (GAP), IDLE in m+2, next tx_start in m+3 at the earliest.
- Minimum turnaround is 4 clk cycles of arbiter overhead per byte plus the transmitter's transfer time.
- ack and done are each exactly one cycle long, never in the same cycle.

## Configuration
- SPI_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to START and to WAIT_DONE and increments each cycle in those states. If it reaches TIMEOUT without the exit condition (tx_ss rise in START, tx_ss fall in WAIT_DONE), the arbiter goes to GAP, drops tx_start, and pulses done[grant_id] and err in the same cycle. last_grant is updated as for a normal completion.
- Not defined: no counter; err is tied 0; START and WAIT_DONE wait indefinitely.

## Test plan
- Single request: req=4'b0001, data[7:0]=0xA5; the TX model raises tx_ss 1 cycle after start for 48 cycles. Required: ack[0] in the cycle after the request, tx_data=0xA5, tx_start drops after tx_ss rises, done[0] exactly 1 cycle after tx_ss falls, busy low 2 cycles after that.
- Simultaneous requests after reset: req=4'b1111 held. Required: grant order 0,1,2,3,0; one ack and one done per transfer.
- Fairness: req[1] and req[3] held high continuously. Required: grants alternate 1,3,1,3; requesters 0 and 2 are never acked.
- Reset mid-transfer: assert rst in WAIT_DONE with grant_id=2. Required: all outputs go to 0 immediately; after release with req=4'b0101, requester 0 is granted first.
- Watchdog, macro defined, TIMEOUT=15, tx_ss tied 0, req[1] high. Required: tx_start high for 15 cycles, then done[1] and err together for one cycle. Without the macro: tx_start stays high and no done is produced.
- Back-to-back: req[0] held with a new byte after each ack. Required: the next tx_start rises exactly 3 cycles after tx_ss is sampled low.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
// Round-robin arbiter sharing one 8-bit SPI transmitter among NREQ byte
// producers. It latches the winner's byte, strobes the transmitter and
// follows tx_ss (high while shifting) to detect completion. It then pulses
// done back to the requester that was granted.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a watchdog that aborts
// a transfer stuck in START or WAIT_DONE after TIMEOUT cycles (done + err).
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   req       per-requester level request, held until ack
//   data      packed request bytes, requester i at [8i+7:8i]
//   ack       one-cycle pulse, byte of requester i latched
//   done      one-cycle pulse, transfer of requester i finished/aborted
//   busy      high in every state except IDLE
//   grant_id  current/last granted requester
//   err       one-cycle pulse with done on watchdog abort (0 without macro)
//   tx_start  start strobe to the transmitter
//   tx_data   byte to the transmitter
//   tx_ss     transmitter slave select, high while shifting
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer, arbitrate among req
// START     | tx_start high, waiting for tx_ss to rise
// WAIT_DONE | byte shifting, waiting for tx_ss to fall
// GAP       | one cycle for the transmitter's post-transfer clear

module spi_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [IDW-1:0]    grant_id,
    output logic              err,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_ss
);

    if (NREQ != 2**IDW) begin : g_bad_nreq
        $error("spi_tx_arbiter: NREQ must equal 2**IDW");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("spi_tx_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;

`ifdef SPI_ARB_TIMEOUT_EN
    // Counter runs 0..TIMEOUT-1, so the state is held for exactly TIMEOUT cycles.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd_cnt;
`else
    assign err = 1'b0;
`endif

    // Search upward from last_grant+1; IDW-bit addition wraps modulo NREQ.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = last_grant;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_grant + IDW'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ack        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NREQ - 1);
`ifdef SPI_ARB_TIMEOUT_EN
            err        <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            ack  <= '0;
            done <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_data  <= data[{winner, 3'b000} +: 8];
                        grant_id <= winner;
                        ack      <= NREQ'(1) << winner;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
`ifdef SPI_ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                START: begin
                    if (tx_ss) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                        wd_cnt   <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        tx_start   <= 1'b0;
                        done       <= NREQ'(1) << grant_id;
                        err        <= 1'b1;
                        last_grant <= grant_id;
                        state      <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!tx_ss) begin
                        done       <= NREQ'(1) << grant_id;
                        last_grant <= grant_id;
                        state      <= GAP;
`ifdef SPI_ARB_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        done       <= NREQ'(1) << grant_id;
                        err        <= 1'b1;
                        last_grant <= grant_id;
                        state      <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
`endif
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
